// File: rtl/output_port_arbiter_if.sv
// Switch-traversal handshake between the input stage, the output port arbiter and the crossbar.
interface output_port_arbiter_if #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
);
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  request_i;   // [in][out]
  logic [PORT_NUM-1:0]                head_i;
  logic [PORT_NUM-1:0]                tail_i;
  logic [PORT_NUM-1:0]                ready_i;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  grant_o;     // [out][in]
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] input_sel_o;
  logic [PORT_NUM-1:0]                valid_o;
  logic [PORT_NUM-1:0]                locked_o;

  modport master (
    output request_i, head_i, tail_i, ready_i,
    input  grant_o, input_sel_o, valid_o, locked_o
  );

  modport slave (
    input  request_i, head_i, tail_i, ready_i,
    output grant_o, input_sel_o, valid_o, locked_o
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Per-output round-robin arbiter; wormhole packet locking is enabled by defining
// OUTPUT_ARBITER_WORMHOLE_LOCK_EN (default build arbitrates every flit independently).
module output_port_arbiter #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  output_port_arbiter_if.slave bus
);

`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  state_e               state_r [PORT_NUM];
  logic [PORT_SIZE-1:0] owner_r [PORT_NUM];
`else
  logic unused_s;
  assign unused_s = ^{bus.head_i, bus.tail_i};
`endif

  logic [PORT_SIZE-1:0]               ptr_r [PORT_NUM];
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_r;
  logic [PORT_NUM-1:0]                valid_r;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  filt_s;    // [in][out], lowest request bit only
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  grant_s;   // [out][in]
  logic [PORT_NUM-1:0]                win_vld_s;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] win_idx_s;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] ptr_nxt_s;
  logic [PORT_SIZE-1:0]               idx_s;
  logic                               head_ok_s;

  // Keep only the lowest-index requested output of each input row.
  always_comb begin
    filt_s = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      filt_s[i] = bus.request_i[i] & (~bus.request_i[i] + PORT_NUM'(1));
    end
  end

  // Pick the winner of every output: owner when locked, round-robin from ptr otherwise.
  always_comb begin
    win_vld_s = '0;
    win_idx_s = '0;
    ptr_nxt_s = '0;
    grant_s   = '0;
    idx_s     = '0;
    head_ok_s = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (rst || !bus.ready_i[o]) begin
        win_vld_s[o] = 1'b0;
`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
      end else if (state_r[o] == LOCKED) begin
        win_vld_s[o] = filt_s[owner_r[o]][o];
        win_idx_s[o] = owner_r[o];
`endif
      end else begin
        // Scan from the far end back toward ptr so the candidate nearest ptr is kept last.
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
          if ((int'(ptr_r[o]) + k) >= PORT_NUM) begin
            idx_s = PORT_SIZE'(int'(ptr_r[o]) + k - PORT_NUM);
          end else begin
            idx_s = PORT_SIZE'(int'(ptr_r[o]) + k);
          end
`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
          head_ok_s = bus.head_i[idx_s];
`else
          head_ok_s = 1'b1;
`endif
          if (filt_s[idx_s][o] && head_ok_s) begin
            win_vld_s[o] = 1'b1;
            win_idx_s[o] = idx_s;
          end else begin
            win_vld_s[o] = win_vld_s[o];
          end
        end
      end
      if (win_idx_s[o] == PORT_SIZE'(PORT_NUM - 1)) begin
        ptr_nxt_s[o] = '0;
      end else begin
        ptr_nxt_s[o] = win_idx_s[o] + PORT_SIZE'(1);
      end
      if (win_vld_s[o]) begin
        grant_s[o][win_idx_s[o]] = 1'b1;
      end else begin
        grant_s[o] = '0;
      end
    end
  end

  // Per-output lock FSM, round-robin pointer and registered crossbar controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        ptr_r[o] <= '0;
`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
        state_r[o] <= IDLE;
        owner_r[o] <= '0;
`endif
      end
      sel_r   <= '0;
      valid_r <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        valid_r[o] <= win_vld_s[o];
        if (win_vld_s[o]) begin
          sel_r[o] <= win_idx_s[o];
`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
          case (state_r[o])
            IDLE: begin
              ptr_r[o] <= ptr_nxt_s[o];
              if (!bus.tail_i[win_idx_s[o]]) begin
                state_r[o] <= LOCKED;
                owner_r[o] <= win_idx_s[o];
              end
            end
            LOCKED: begin
              if (bus.tail_i[owner_r[o]]) begin
                state_r[o] <= IDLE;
              end
            end
            default: state_r[o] <= IDLE;
          endcase
`else
          ptr_r[o] <= ptr_nxt_s[o];
`endif
        end
      end
    end
  end

  assign bus.grant_o     = grant_s;
  assign bus.input_sel_o = sel_r;
  assign bus.valid_o     = valid_r;

`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_locked
    assign bus.locked_o[o] = (state_r[o] == LOCKED);
  end
`else
  assign bus.locked_o = '0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter with a per-cycle reference model and literal expectations.
module tb_output_port_arbiter;
  localparam int N = 5;
`ifdef OUTPUT_ARBITER_WORMHOLE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.PORT_NUM(N)) bus ();
  output_port_arbiter #(.PORT_NUM(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet ownership and pointers held as plain integers.
  bit m_locked [N];
  int m_owner  [N];
  int m_ptr    [N];
  bit m_valid  [N];
  int m_sel    [N];
  int tgt      [N];
  int win;
  int c;

  always @(negedge clk) begin
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        m_locked[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0; m_valid[o] = 1'b0; m_sel[o] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      tgt[i] = -1;
      for (int o = N - 1; o >= 0; o--) if (bus.request_i[i][o]) tgt[i] = o;
    end
    for (int o = 0; o < N; o++) begin
      win = -1;
      if (!rst && bus.ready_i[o]) begin
        if (m_locked[o]) begin
          if (tgt[m_owner[o]] == o) win = m_owner[o];
        end else begin
          for (int k = 0; k < N; k++) begin
            c = (m_ptr[o] + k) % N;
            if (win < 0 && tgt[c] == o && (!LOCK_EN || bus.head_i[c])) win = c;
          end
        end
      end
      chk($sformatf("model_grant[%0d]", o), int'(bus.grant_o[o]), (win < 0) ? 0 : (1 << win));
      chk($sformatf("model_valid[%0d]", o), int'(bus.valid_o[o]), int'(m_valid[o]));
      chk($sformatf("model_sel[%0d]", o), int'(bus.input_sel_o[o]), m_sel[o]);
      chk($sformatf("model_locked[%0d]", o), int'(bus.locked_o[o]), int'(m_locked[o]));
      if (!rst) begin
        m_valid[o] = (win >= 0);
        if (win >= 0) begin
          m_sel[o] = win;
          if (!m_locked[o]) begin
            m_ptr[o] = (win + 1) % N;
            if (LOCK_EN && !bus.tail_i[win]) begin
              m_locked[o] = 1'b1;
              m_owner[o]  = win;
            end
          end else if (bus.tail_i[win]) begin
            m_locked[o] = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [N-1:0][N-1:0] rq(input int in, input int out);
    logic [N-1:0][N-1:0] r;
    r = '0;
    r[in][out] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic [N-1:0][N-1:0] req, input logic [N-1:0] hd,
                       input logic [N-1:0] tl, input logic [N-1:0] rdy);
    @(posedge clk);
    #2;
    bus.request_i = req;
    bus.head_i    = hd;
    bus.tail_i    = tl;
    bus.ready_i   = rdy;
    #1;
  endtask

  int rr_exp [4] = '{0, 2, 3, 0};

  initial begin
    rst = 1'b1;
    bus.request_i = 25'($urandom);
    bus.head_i    = '1;
    bus.tail_i    = '1;
    bus.ready_i   = '1;
    @(posedge clk);
    #1;
    chk("rst_grant", int'(bus.grant_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_sel", int'(bus.input_sel_o), 0);
    chk("rst_locked", int'(bus.locked_o), 0);
    bus.request_i = '0;
    rst = 1'b0;

    // First grant after reset starts scanning at index 0.
    drive(rq(1, 2) | rq(3, 2), '1, '1, '1);
    chk("post_rst_grant", int'(bus.grant_o[2]), 5'b00010);

    // Round robin among single-flit packets from inputs 0, 2, 3 to out 1.
    for (int k = 0; k < 4; k++) begin
      drive(rq(0, 1) | rq(2, 1) | rq(3, 1), '1, '1, '1);
      chk("rr_grant", int'(bus.grant_o[1]), 1 << rr_exp[k]);
      if (k > 0) begin
        chk("rr_sel", int'(bus.input_sel_o[1]), rr_exp[k-1]);
        chk("rr_valid", int'(bus.valid_o[1]), 1);
      end
    end

    // Row filter: only the lowest requested output of input 2 is considered.
    drive(rq(2, 1) | rq(2, 3), '1, '1, '1);
    chk("rr_last_sel", int'(bus.input_sel_o[1]), 0);
    chk("filter_grant1", int'(bus.grant_o[1]), 5'b00100);
    chk("filter_grant3", int'(bus.grant_o[3]), 0);

    // Packet from input 4 with input 1 contending from the second flit.
    drive(rq(4, 0), 5'b10000, 5'b00000, '1);
    chk("lock_c0_grant", int'(bus.grant_o[0]), 5'b10000);
    drive(rq(4, 0) | rq(1, 0), 5'b00010, 5'b00010, '1);
    chk("lock_c1_grant", int'(bus.grant_o[0]), LOCK_EN ? 5'b10000 : 5'b00010);
    chk("lock_c1_locked", int'(bus.locked_o[0]), LOCK_EN ? 1 : 0);
    drive(rq(4, 0) | rq(1, 0), 5'b00010, 5'b10010, '1);
    chk("lock_c2_grant", int'(bus.grant_o[0]), 5'b10000);
    chk("lock_c2_locked", int'(bus.locked_o[0]), LOCK_EN ? 1 : 0);
    drive(rq(1, 0), 5'b00010, 5'b00010, '1);
    chk("lock_c3_grant", int'(bus.grant_o[0]), 5'b00010);
    chk("lock_c3_locked", int'(bus.locked_o[0]), 0);

    // Backpressure in the middle of a packet.
    drive(rq(4, 0), 5'b10000, 5'b00000, '1);
    chk("bp_c0_grant", int'(bus.grant_o[0]), 5'b10000);
    drive(rq(4, 0), 5'b00000, 5'b00000, 5'b11110);
    chk("bp_c1_grant", int'(bus.grant_o[0]), 0);
    chk("bp_c1_locked", int'(bus.locked_o[0]), LOCK_EN ? 1 : 0);
    drive(rq(4, 0), 5'b00000, 5'b00000, '1);
    chk("bp_c2_grant", int'(bus.grant_o[0]), 5'b10000);
    chk("bp_c2_valid", int'(bus.valid_o[0]), 0);
    chk("bp_c2_locked", int'(bus.locked_o[0]), LOCK_EN ? 1 : 0);
    drive(rq(4, 0), 5'b00000, 5'b10000, '1);
    chk("bp_c3_grant", int'(bus.grant_o[0]), 5'b10000);
    chk("bp_c3_valid", int'(bus.valid_o[0]), 1);
    drive('0, '0, '0, '1);
    chk("bp_c4_sel", int'(bus.input_sel_o[0]), 4);
    chk("bp_c4_locked", int'(bus.locked_o[0]), 0);

    // Reset while a packet holds out 0.
    drive(rq(4, 0), 5'b10000, 5'b00000, '1);
    chk("rstmid_c0_grant", int'(bus.grant_o[0]), 5'b10000);
    drive(rq(4, 0), 5'b00000, 5'b00000, '1);
    chk("rstmid_c1_locked", int'(bus.locked_o[0]), LOCK_EN ? 1 : 0);
    rst = 1'b1;
    #1;
    chk("rstmid_async_locked", int'(bus.locked_o[0]), 0);
    chk("rstmid_async_grant", int'(bus.grant_o), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.request_i = rq(3, 0);
    bus.head_i    = 5'b01000;
    bus.tail_i    = 5'b00000;
    #1;
    chk("rstmid_new_head", int'(bus.grant_o[0]), 5'b01000);

    // Lone body flit: granted only when locking is compiled out.
    drive(rq(2, 4), 5'b00000, 5'b00000, '1);
    chk("body_alone", int'(bus.grant_o[4]), LOCK_EN ? 0 : 5'b00100);

    // Mixed traffic checked by the model alone.
    for (int k = 0; k < 300; k++) begin
      drive(25'($urandom), 5'($urandom), 5'($urandom), 5'($urandom) | 5'($urandom));
    end
    drive('0, '0, '0, '1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
